alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001 SHALL have parameter N, default 32: operand/result width in bits.
- REQ-002 SHALL have parameter NREQ, fixed at 4: number of requesters; not overridable.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst  input  1  reset; synchronous, active-high.
- REQ-005 req  input  4  per-requester request; bit i = requester i.
- REQ-006 op  input  16  per-requester opcode; op[4i+3:4i] belongs to requester i.
- REQ-007 a_in  input  4*N  operand A; a_in[N*i+N-1:N*i] belongs to requester i.
- REQ-008 b_in  input  4*N  operand B; same slicing as a_in.
- REQ-009 gnt  output  4  one-hot grant pulse; operands of that requester have been latched.
- REQ-010 done  output  4  one-hot completion pulse to the granted requester.
- REQ-011 result  output  N  registered result; valid while done is non-zero.
- REQ-012 flags  output  4  registered ALU flags; valid while done is non-zero.
- REQ-013 err  output  1  invalid-opcode indication; valid while done is non-zero.
- REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
- REQ-015 alu_a, alu_b  output  N each  registered operands to the shared combinational ALU.
- REQ-016 alu_op  output  4  registered opcode to the shared ALU.
- REQ-017 alu_result  input  N, alu_flags  input  4  combinational ALU outputs.

Function
- REQ-018 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC when any req bit is set; EXEC->RESP unconditionally; RESP->IDLE unconditionally.
- REQ-019 In IDLE with req != 0: SHALL select the winner by round-robin, searching ptr, ptr+1, ... mod 4; the first set bit wins.
- REQ-020 On the IDLE->EXEC edge: SHALL load alu_a/alu_b/alu_op from the winner's slices and set gnt to the winner's one-hot for exactly one cycle (the EXEC cycle).
- REQ-021 On the EXEC->RESP edge: SHALL capture alu_result/alu_flags into result/flags.
- REQ-022 Valid opcodes: 0 sum, 1 sub, 2 mul, 3 div, 4 mod, 5 mov.
- REQ-023 For an opcode in 6..15: SHALL capture result=0, flags=0, err=1 instead of the ALU outputs; err SHALL be 0 for valid opcodes.
- REQ-024 done SHALL equal the winner's one-hot for exactly one cycle (the RESP cycle); result/flags/err SHALL hold their values until the next capture.
- REQ-025 Latency: req first seen in IDLE at cycle t -> gnt at t+1 -> done at t+2 -> next arbitration at t+3; throughput one operation per 3 cycles.
- REQ-026 On the RESP->IDLE edge: SHALL set ptr = (winner+1) mod 4.
- REQ-027 req changes during EXEC/RESP SHALL be ignored; no pre-emption.
- REQ-028 A requester still asserting req in the IDLE cycle after its done SHALL be treated as a new request.
- REQ-029 Requesters SHALL hold req/op/a_in/b_in stable until gnt; the arbiter does not sample them after the grant edge.
- REQ-030 Divide/mod by zero SHALL be passed to the ALU unmodified; err=0.

Reset
- REQ-031 While rst=1 at a clock edge: state=IDLE, ptr=0; gnt, done, result, flags, err, busy, alu_a, alu_b, alu_op all 0.
- REQ-032 rst in EXEC or RESP SHALL abort the in-flight operation: no done is issued and the operation is not retried.
- REQ-033 rst SHALL take priority over every other transition in the same cycle.

Verification
- REQ-034 After reset, req=0001, op0=0, a0=5, b0=3 -> gnt=0001 at t+1, done=0001 at t+2, result=8, err=0.
- REQ-035 req=1111 held, each requester drops req after its gnt -> gnt order 0001, 0010, 0100, 1000 at 3-cycle spacing; busy high throughout.
- REQ-036 req0 and req2 held continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never granted.
- REQ-037 req=0010, op1=4'hF -> done=0010, result=0, flags=0, err=1.
- REQ-038 req=0001, rst pulsed during the EXEC cycle -> no done pulse; all outputs 0; then req=1000 alone -> gnt=1000 one cycle after the first IDLE cycle.
- REQ-039 req=0100, op2=3, a2=20, b2=0 -> alu_op=3 and alu_b=0 presented; done=0100 with result/flags equal to the ALU model's outputs; err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter that shares one external combinational ALU among four
//   requesters. One operation is handled every three cycles:
//     IDLE : pick a winner, latch its operands/opcode onto alu_a/alu_b/alu_op
//     EXEC : gnt pulse to the winner; ALU settles on the latched operands
//     RESP : done pulse to the winner; result/flags/err are already captured
//   The round-robin pointer moves to the requester after the winner when the
//   FSM returns to IDLE.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req[3:0]           per-requester request
//   op[15:0]           per-requester opcode, op[4i+3:4i] for requester i
//   a_in/b_in[4N-1:0]  per-requester operands, [N*i+N-1:N*i] for requester i
//   gnt[3:0]           one-hot grant pulse (operands latched)
//   done[3:0]          one-hot completion pulse
//   result, flags, err registered outcome, held until the next capture
//   busy               high whenever the FSM is not in IDLE
//   alu_a, alu_b, alu_op  registered inputs of the shared ALU
//   alu_result, alu_flags combinational outputs of the shared ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter  int N    = 32,
    localparam int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] op,
    input  logic [NREQ*N-1:0] a_in,
    input  logic [NREQ*N-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [N-1:0]      result,
    output logic [3:0]        flags,
    output logic              err,
    output logic              busy,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [3:0]        alu_op,
    input  logic [N-1:0]      alu_result,
    input  logic [3:0]        alu_flags
);

    localparam int IW = $clog2(NREQ);
    localparam logic [3:0] OP_LAST_VALID = 4'd5;  // 0 sum .. 5 mov

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state_q,  state_d;
    idx_t            ptr_q,    ptr_d;
    idx_t            winner_q, winner_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] done_q,   done_d;
    logic [N-1:0]    result_q, result_d;
    logic [3:0]      flags_q,  flags_d;
    logic            err_q,    err_d;
    logic [N-1:0]    alu_a_q,  alu_a_d;
    logic [N-1:0]    alu_b_q,  alu_b_d;
    logic [3:0]      alu_op_q, alu_op_d;

    // Round-robin search starting at ptr_q; index arithmetic wraps mod NREQ.
    logic win_found;
    idx_t win_idx;
    idx_t cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr_q + IW'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = '0;
        done_d   = '0;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    winner_d = win_idx;
                    alu_a_d  = a_in[N*win_idx +: N];
                    alu_b_d  = b_in[N*win_idx +: N];
                    alu_op_d = op[4*win_idx +: 4];
                    gnt_d    = NREQ'(1) << win_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Invalid opcodes never expose whatever the ALU produced.
                if (alu_op_q <= OP_LAST_VALID) begin
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    err_d    = 1'b0;
                end else begin
                    result_d = '0;
                    flags_d  = '0;
                    err_d    = 1'b1;
                end
                done_d  = NREQ'(1) << winner_q;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = winner_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A small behavioural ALU closes the loop on
//   alu_a/alu_b/alu_op. Inputs change and outputs are sampled on the falling
//   edge, so each negedge after a request sees one FSM state: EXEC, RESP, IDLE.
//   ALU model: flags = {negative, zero, 0, divide_by_zero}; x/0 gives all
//   ones, x%0 gives x; undefined opcodes give a^b with flags 4'hF so that the
//   arbiter's zeroing of invalid results is observable.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [15:0]   op;
    logic [4*N-1:0] a_in;
    logic [4*N-1:0] b_in;
    logic [3:0]    gnt;
    logic [3:0]    done;
    logic [N-1:0]  result;
    logic [3:0]    flags;
    logic          err;
    logic          busy;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_result;
    logic [3:0]    alu_flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .flags     (flags),
        .err       (err),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_flags (alu_flags)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU model.
    logic dz;
    always_comb begin
        alu_result = '0;
        dz         = 1'b0;
        case (alu_op)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a * alu_b;
            4'd3: begin dz = (alu_b == '0); alu_result = dz ? '1 : alu_a / alu_b; end
            4'd4: begin dz = (alu_b == '0); alu_result = dz ? alu_a : alu_a % alu_b; end
            4'd5: alu_result = alu_a;
            default: alu_result = alu_a ^ alu_b;
        endcase
        if (alu_op <= 4'd5) alu_flags = {alu_result[N-1], alu_result == '0, 1'b0, dz};
        else                alu_flags = 4'hF;
    end

    task automatic do_reset();
        rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; op = 16'h1234; a_in = '1; b_in = '1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0)    begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++; if (done !== 4'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
        n_cmp++; if (result !== '0)   begin n_err++; $display("FAIL reset_result: got %0h want 0", result); end
        n_cmp++; if (flags !== 4'b0)  begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
        n_cmp++; if (err !== 1'b0)    begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (alu_a !== '0)    begin n_err++; $display("FAIL reset_alu_a: got %0h want 0", alu_a); end
        n_cmp++; if (alu_b !== '0)    begin n_err++; $display("FAIL reset_alu_b: got %0h want 0", alu_b); end
        n_cmp++; if (alu_op !== 4'b0) begin n_err++; $display("FAIL reset_alu_op: got %0h want 0", alu_op); end
        rst = 1'b0; req = '0; op = '0; a_in = '0; b_in = '0;
    endtask

    // req0 sum 5+3.
    task automatic test_sum();
        do_reset();
        req = 4'b0001; op[3:0] = 4'd0; a_in[N-1:0] = 5; b_in[N-1:0] = 3;
        @(negedge clk);  // EXEC
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL sum_gnt: got %b want 0001", gnt); end
        n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL sum_busy_exec: got %b want 1", busy); end
        n_cmp++; if (alu_a !== 5 || alu_b !== 3) begin n_err++; $display("FAIL sum_operands: got %0d,%0d want 5,3", alu_a, alu_b); end
        n_cmp++; if (done !== 4'b0)   begin n_err++; $display("FAIL sum_done_early: got %b want 0000", done); end
        req = 4'b0000;
        @(negedge clk);  // RESP
        n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL sum_done: got %b want 0001", done); end
        n_cmp++; if (gnt !== 4'b0)     begin n_err++; $display("FAIL sum_gnt_pulse: got %b want 0000", gnt); end
        n_cmp++; if (result !== 8)     begin n_err++; $display("FAIL sum_result: got %0d want 8", result); end
        n_cmp++; if (flags !== 4'b0)   begin n_err++; $display("FAIL sum_flags: got %b want 0000", flags); end
        n_cmp++; if (err !== 1'b0)     begin n_err++; $display("FAIL sum_err: got %b want 0", err); end
        @(negedge clk);  // IDLE
        n_cmp++; if (done !== 4'b0)    begin n_err++; $display("FAIL sum_done_pulse: got %b want 0000", done); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL sum_busy_idle: got %b want 0", busy); end
        n_cmp++; if (result !== 8)     begin n_err++; $display("FAIL sum_result_hold: got %0d want 8", result); end
    endtask

    // All four request; each drops after its grant; a_k=10+k, b_k=k.
    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a_in[N*k +: N] = N'(10 + k);
            b_in[N*k +: N] = N'(k);
        end
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);  // EXEC
            n_cmp++; if (gnt !== 4'(1 << k)) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, 4'(1 << k)); end
            n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL rr_busy_exec%0d: got %b want 1", k, busy); end
            req[k] = 1'b0;
            @(negedge clk);  // RESP
            n_cmp++; if (done !== 4'(1 << k)) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", k, done, 4'(1 << k)); end
            n_cmp++; if (result !== N'(10 + 2 * k)) begin n_err++; $display("FAIL rr_result%0d: got %0d want %0d", k, result, 10 + 2 * k); end
            n_cmp++; if (busy !== 1'b1)       begin n_err++; $display("FAIL rr_busy_resp%0d: got %b want 1", k, busy); end
            @(negedge clk);  // IDLE
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_end: got %b want 0", busy); end
    endtask

    // req0 and req2 held: grants alternate 0,2,0,2.
    task automatic test_alternate();
        logic [3:0] exp_g [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== exp_g[k]) begin n_err++; $display("FAIL alt_gnt%0d: got %b want %b", k, gnt, exp_g[k]); end
            @(negedge clk);
            n_cmp++; if (done !== exp_g[k]) begin n_err++; $display("FAIL alt_done%0d: got %b want %b", k, done, exp_g[k]); end
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    // req1 with undefined opcode F.
    task automatic test_invalid_op();
        do_reset();
        req = 4'b0010; op[7:4] = 4'hF; a_in[N +: N] = 7; b_in[N +: N] = 9;
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'hF || gnt !== 4'b0010) begin n_err++; $display("FAIL inv_grant: got op %0h gnt %b want F 0010", alu_op, gnt); end
        req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL inv_done: got %b want 0010", done); end
        n_cmp++; if (result !== '0)    begin n_err++; $display("FAIL inv_result: got %0h want 0", result); end
        n_cmp++; if (flags !== 4'b0)   begin n_err++; $display("FAIL inv_flags: got %b want 0000", flags); end
        n_cmp++; if (err !== 1'b1)     begin n_err++; $display("FAIL inv_err: got %b want 1", err); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b1)     begin n_err++; $display("FAIL inv_err_hold: got %b want 1", err); end
    endtask

    // Reset during EXEC aborts; then req3 alone is granted.
    task automatic test_reset_abort();
        do_reset();
        req = 4'b0001; op[3:0] = 4'd5; a_in[N-1:0] = 77;
        @(negedge clk);  // EXEC
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL abort_gnt0: got %b want 0001", gnt); end
        rst = 1'b1; req = 4'b0000;
        @(negedge clk);  // reset applied
        n_cmp++; if (done !== 4'b0)  begin n_err++; $display("FAIL abort_done: got %b want 0000", done); end
        n_cmp++; if (gnt !== 4'b0)   begin n_err++; $display("FAIL abort_gnt_clr: got %b want 0000", gnt); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (result !== '0 || alu_a !== '0 || alu_op !== 4'b0) begin n_err++; $display("FAIL abort_regs: got result %0h alu_a %0h alu_op %0h want 0", result, alu_a, alu_op); end
        rst = 1'b0; req = 4'b1000;
        @(negedge clk);  // one cycle after the first IDLE cycle
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL abort_gnt3: got %b want 1000", gnt); end
        n_cmp++; if (done !== 4'b0)   begin n_err++; $display("FAIL abort_no_done: got %b want 0000", done); end
        req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (done !== 4'b1000) begin n_err++; $display("FAIL abort_done3: got %b want 1000", done); end
        @(negedge clk);
    endtask

    // req2 divide 20 by zero: model gives all ones, flags {1,0,0,1}.
    task automatic test_div_zero();
        do_reset();
        req = 4'b0100; op[11:8] = 4'd3; a_in[2*N +: N] = 20; b_in[2*N +: N] = 0;
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd3) begin n_err++; $display("FAIL dz_alu_op: got %0d want 3", alu_op); end
        n_cmp++; if (alu_a !== 20 || alu_b !== 0) begin n_err++; $display("FAIL dz_operands: got %0d,%0d want 20,0", alu_a, alu_b); end
        req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (done !== 4'b0100)       begin n_err++; $display("FAIL dz_done: got %b want 0100", done); end
        n_cmp++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_result: got %0h want ffffffff", result); end
        n_cmp++; if (flags !== 4'b1001)      begin n_err++; $display("FAIL dz_flags: got %b want 1001", flags); end
        n_cmp++; if (err !== 1'b0)           begin n_err++; $display("FAIL dz_err: got %b want 0", err); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0;
        test_reset();
        test_sum();
        test_round_robin();
        test_alternate();
        test_invalid_op();
        test_reset_abort();
        test_div_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
